// File: rtl/result_mem_reader.sv
// ---------------------------------------------------------------------------
// result_mem_reader
//
// Purpose:
//   Reads an N x N result matrix back out of the result memory. The matrix
//   is stored row-major starting at a base address. Each row is gathered
//   into an N-lane buffer through a synchronous-read memory port (one cycle
//   of read latency). The buffered row is then presented to a consumer with
//   a valid/ready handshake. A single-cycle done pulse follows acceptance of
//   the last row.
//
// Configuration macro:
//   RESULT_READER_TRANSPOSE_EN - when defined, elements are fetched
//   column-major (base + col*N + row). Each presented row is then a column
//   of the stored matrix. Timing and handshake are unchanged.
//
// Ports:
//   clk          - clock, everything on the rising edge
//   rst          - synchronous active-high reset (aborts any transfer)
//   start        - single-cycle request, only honoured while idle
//   base_address - address of element [0][0], latched on an accepted start
//   mem_rd_en    - memory read strobe (asserted only while fetching)
//   mem_addr     - memory read address (wraps modulo 2^ADDR_W)
//   mem_rdata    - memory read data, valid the cycle after mem_rd_en
//   out0..out4   - row lanes, column 0..4 (the port list assumes N = 5)
//   out_row      - index of the row being presented
//   out_valid    - row on the lanes is valid
//   out_ready    - consumer accepts the row when out_valid && out_ready
//   busy         - high from the cycle after an accepted start until done
//   done         - one-cycle pulse after the last row is accepted
// ---------------------------------------------------------------------------
module result_mem_reader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int N      = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_address,
  output logic                 mem_rd_en,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic [DATA_W-1:0]    mem_rdata,
  output logic [DATA_W-1:0]    out0,
  output logic [DATA_W-1:0]    out1,
  output logic [DATA_W-1:0]    out2,
  output logic [DATA_W-1:0]    out3,
  output logic [DATA_W-1:0]    out4,
  output logic [$clog2(N)-1:0] out_row,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 done
);

  localparam int RW = $clog2(N);
  localparam logic [RW-1:0] LAST_IDX = RW'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_FILL,
    S_PRESENT,
    S_DONE
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   baseAddr_q;
  logic [ADDR_W-1:0]   memAddr_q;
  logic                memRdEn_q;
  logic [RW-1:0]       rowCnt_q;
  logic [RW-1:0]       colCnt_q;
  logic [RW-1:0]       colDly_q;
  logic                rdPending_q;
  logic [DATA_W-1:0]   lane_q [N];
  logic [RW-1:0]       outRow_q;
  logic                outValid_q;
  logic                busy_q;
  logic                done_q;

  // Element address for (row, col). The offset is truncated to ADDR_W bits
  // so a matrix that runs past the top of memory wraps back to address 0.
  function automatic logic [ADDR_W-1:0] elemAddr(
    input logic [ADDR_W-1:0] base,
    input logic [RW-1:0]     row,
    input logic [RW-1:0]     col
  );
    logic [31:0] offset;
`ifdef RESULT_READER_TRANSPOSE_EN
    offset = 32'(col) * 32'(N) + 32'(row);
`else
    offset = 32'(row) * 32'(N) + 32'(col);
`endif
    return base + offset[ADDR_W-1:0];
  endfunction

  // Main FSM and datapath. The memory answers one cycle after the strobe,
  // so the strobe and the column it fetched are delayed by one cycle
  // (rdPending_q / colDly_q) to steer the returning word into its lane.
  // The FILL state exists only to let the last word of a row land before
  // the row is presented. Address and strobe are registered one step
  // ahead so they line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      baseAddr_q  <= '0;
      memAddr_q   <= '0;
      memRdEn_q   <= 1'b0;
      rowCnt_q    <= '0;
      colCnt_q    <= '0;
      colDly_q    <= '0;
      rdPending_q <= 1'b0;
      outRow_q    <= '0;
      outValid_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      for (int i = 0; i < N; i++) begin
        lane_q[i] <= '0;
      end
    end else begin
      rdPending_q <= memRdEn_q;
      colDly_q    <= colCnt_q;
      done_q      <= 1'b0;

      if (rdPending_q) begin
        lane_q[colDly_q] <= mem_rdata;
      end

      case (state_q)
        S_IDLE: begin
          if (start) begin
            baseAddr_q <= base_address;
            rowCnt_q   <= '0;
            colCnt_q   <= '0;
            memRdEn_q  <= 1'b1;
            memAddr_q  <= elemAddr(base_address, '0, '0);
            busy_q     <= 1'b1;
            state_q    <= S_READ;
          end
        end

        S_READ: begin
          if (colCnt_q == LAST_IDX) begin
            memRdEn_q <= 1'b0;
            state_q   <= S_FILL;
          end else begin
            colCnt_q  <= colCnt_q + RW'(1);
            memAddr_q <= elemAddr(baseAddr_q, rowCnt_q, colCnt_q + RW'(1));
          end
        end

        S_FILL: begin
          outValid_q <= 1'b1;
          outRow_q   <= rowCnt_q;
          state_q    <= S_PRESENT;
        end

        S_PRESENT: begin
          if (out_ready) begin
            outValid_q <= 1'b0;
            if (rowCnt_q == LAST_IDX) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              rowCnt_q  <= rowCnt_q + RW'(1);
              colCnt_q  <= '0;
              memRdEn_q <= 1'b1;
              memAddr_q <= elemAddr(baseAddr_q, rowCnt_q + RW'(1), '0);
              state_q   <= S_READ;
            end
          end
        end

        S_DONE: begin
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_rd_en = memRdEn_q;
  assign mem_addr  = memAddr_q;
  assign out_row   = outRow_q;
  assign out_valid = outValid_q;
  assign busy      = busy_q;
  assign done      = done_q;

  assign out0 = lane_q[0];
  assign out1 = lane_q[1];
  assign out2 = lane_q[2];
  assign out3 = lane_q[3];
  assign out4 = lane_q[4];

endmodule

// File: tb/tb_result_mem_reader.sv
// ---------------------------------------------------------------------------
// tb_result_mem_reader
//
// Self-checking bench for result_mem_reader. A 1-cycle-latency memory model
// holds mem[i] = i+1. Expected rows and valid cycles come from hand-written
// tables. Expectations follow RESULT_READER_TRANSPOSE_EN when it is defined.
// ---------------------------------------------------------------------------
module tb_result_mem_reader;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 8;
  localparam int N      = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] baseAddress;
  logic              memRdEn;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memRdata = '0;
  logic [DATA_W-1:0] out0, out1, out2, out3, out4;
  logic [2:0]        outRow;
  logic              outValid;
  logic              outReady;
  logic              busy;
  logic              done;

  result_mem_reader #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .N     (N)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .base_address(baseAddress),
    .mem_rd_en   (memRdEn),
    .mem_addr    (memAddr),
    .mem_rdata   (memRdata),
    .out0        (out0),
    .out1        (out1),
    .out2        (out2),
    .out3        (out3),
    .out4        (out4),
    .out_row     (outRow),
    .out_valid   (outValid),
    .out_ready   (outReady),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Memory model: contents are address + 1, one cycle of read latency.
  always @(posedge clk) begin
    if (memRdEn) begin
      memRdata <= DATA_W'(memAddr) + 32'd1;
    end
  end

  // Event monitor: handshakes, done pulses, and read strobes that show up
  // while a row is being presented or done is high.
  int hsCount = 0;
  int doneCount = 0;
  int rdEnViol = 0;
  always @(posedge clk) begin
    if (!rst) begin
      if (outValid && outReady) hsCount++;
      if (done) doneCount++;
      if (memRdEn && (outValid || done)) rdEnViol++;
    end
  end

  typedef struct {
    int rowIdx;
    int offset;
    int stall;
    int lanes[5];
  } rowVec_t;

  rowVec_t vecs[5];
  int cyc = 0;
  int t0Cyc = 0;
  int passCount = 0;
  int checkCount = 0;
  int hsBase;
  int doneBase;

  task automatic nextCycle();
    @(negedge clk);
    cyc++;
  endtask

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checkCount++;
    if (actual == expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic longint laneVal(input int i);
    case (i)
      0:       return longint'(out0);
      1:       return longint'(out1);
      2:       return longint'(out2);
      3:       return longint'(out3);
      default: return longint'(out4);
    endcase
  endfunction

  task automatic setVec(input int i, input int r, input int off, input int st,
                        input int a, input int b, input int c, input int d, input int e);
    vecs[i].rowIdx   = r;
    vecs[i].offset   = off;
    vecs[i].stall    = st;
    vecs[i].lanes[0] = a;
    vecs[i].lanes[1] = b;
    vecs[i].lanes[2] = c;
    vecs[i].lanes[3] = d;
    vecs[i].lanes[4] = e;
  endtask

  // Base 0 with no backpressure: row r valid at t0+7+7r.
  task automatic fillBasic();
`ifdef RESULT_READER_TRANSPOSE_EN
    setVec(0, 0,  7, 0, 1, 6, 11, 16, 21);
    setVec(1, 1, 14, 0, 2, 7, 12, 17, 22);
    setVec(2, 2, 21, 0, 3, 8, 13, 18, 23);
    setVec(3, 3, 28, 0, 4, 9, 14, 19, 24);
    setVec(4, 4, 35, 0, 5, 10, 15, 20, 25);
`else
    setVec(0, 0,  7, 0,  1,  2,  3,  4,  5);
    setVec(1, 1, 14, 0,  6,  7,  8,  9, 10);
    setVec(2, 2, 21, 0, 11, 12, 13, 14, 15);
    setVec(3, 3, 28, 0, 16, 17, 18, 19, 20);
    setVec(4, 4, 35, 0, 21, 22, 23, 24, 25);
`endif
  endtask

  // Base 250: addresses wrap past 255 back to 0.
  task automatic fillWrap();
`ifdef RESULT_READER_TRANSPOSE_EN
    setVec(0, 0,  7, 0, 251, 256, 5, 10, 15);
    setVec(1, 1, 14, 0, 252,   1, 6, 11, 16);
    setVec(2, 2, 21, 0, 253,   2, 7, 12, 17);
    setVec(3, 3, 28, 0, 254,   3, 8, 13, 18);
    setVec(4, 4, 35, 0, 255,   4, 9, 14, 19);
`else
    setVec(0, 0,  7, 0, 251, 252, 253, 254, 255);
    setVec(1, 1, 14, 0, 256,   1,   2,   3,   4);
    setVec(2, 2, 21, 0,   5,   6,   7,   8,   9);
    setVec(3, 3, 28, 0,  10,  11,  12,  13,  14);
    setVec(4, 4, 35, 0,  15,  16,  17,  18,  19);
`endif
  endtask

  // Pulses start for one cycle; returns in cycle t0+1.
  task automatic applyStimulus(input logic [ADDR_W-1:0] base, input string tag);
    baseAddress = base;
    start       = 1'b1;
    t0Cyc       = cyc;
    nextCycle();
    start       = 1'b0;
    checkOutput({tag, " busy at t0+1"}, busy, 1);
    checkOutput({tag, " mem_rd_en at t0+1"}, memRdEn, 1);
    checkOutput({tag, " mem_addr at t0+1"}, memAddr, base);
  endtask

  task automatic waitValid(input string tag);
    int n = 0;
    while (!outValid && n < 100) begin
      nextCycle();
      n++;
    end
    if (!outValid) checkOutput({tag, " timeout waiting for out_valid"}, 0, 1);
  endtask

  task automatic runTable(input int count, input bit finishRun, input string tag);
    for (int i = 0; i < count; i++) begin
      waitValid(tag);
      checkOutput($sformatf("%s row%0d valid cycle", tag, i), cyc - t0Cyc, vecs[i].offset);
      checkOutput($sformatf("%s row%0d out_row", tag, i), outRow, vecs[i].rowIdx);
      checkOutput($sformatf("%s row%0d busy", tag, i), busy, 1);
      checkOutput($sformatf("%s row%0d done low", tag, i), done, 0);
      for (int l = 0; l < 5; l++) begin
        checkOutput($sformatf("%s row%0d out%0d", tag, i, l), laneVal(l), vecs[i].lanes[l]);
      end
      if (vecs[i].stall > 0) begin
        outReady = 1'b0;
        repeat (vecs[i].stall) nextCycle();
        checkOutput($sformatf("%s row%0d valid held", tag, i), outValid, 1);
        checkOutput($sformatf("%s row%0d out_row held", tag, i), outRow, vecs[i].rowIdx);
        for (int l = 0; l < 5; l++) begin
          checkOutput($sformatf("%s row%0d out%0d held", tag, i, l), laneVal(l), vecs[i].lanes[l]);
        end
        outReady = 1'b1;
      end
      nextCycle();
    end
    if (finishRun) begin
      checkOutput({tag, " done after last row"}, done, 1);
      checkOutput({tag, " busy low with done"}, busy, 0);
      checkOutput({tag, " out_valid low with done"}, outValid, 0);
      nextCycle();
      checkOutput({tag, " done is one cycle"}, done, 0);
    end
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    baseAddress = '0;
    outReady    = 1'b1;
    repeat (3) nextCycle();

    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset out_valid", outValid, 0);
    checkOutput("reset mem_rd_en", memRdEn, 0);
    checkOutput("reset mem_addr", memAddr, 0);
    checkOutput("reset out_row", outRow, 0);
    for (int l = 0; l < 5; l++) checkOutput($sformatf("reset out%0d", l), laneVal(l), 0);

    rst = 1'b0;
    nextCycle();

    // Basic read
    $display("[TB] basic read");
    fillBasic();
    hsBase = hsCount; doneBase = doneCount;
    applyStimulus(8'd0, "basic");
    runTable(5, 1'b1, "basic");
    checkOutput("basic busy after", busy, 0);
    checkOutput("basic handshakes", hsCount - hsBase, 5);
    checkOutput("basic done count", doneCount - doneBase, 1);

    // Backpressure on row 1
    $display("[TB] backpressure");
    nextCycle();
    fillBasic();
    vecs[1].stall  = 3;
    vecs[2].offset = 24;
    vecs[3].offset = 31;
    vecs[4].offset = 38;
    hsBase = hsCount; doneBase = doneCount;
    applyStimulus(8'd0, "bp");
    runTable(5, 1'b1, "bp");
    checkOutput("bp handshakes", hsCount - hsBase, 5);
    checkOutput("bp done count", doneCount - doneBase, 1);

    // Address wrap
    $display("[TB] address wrap");
    nextCycle();
    fillWrap();
    applyStimulus(8'd250, "wrap");
    runTable(5, 1'b1, "wrap");

    // Second start while busy is ignored
    $display("[TB] ignored start");
    nextCycle();
    fillBasic();
    hsBase = hsCount; doneBase = doneCount;
    applyStimulus(8'd0, "ign");
    nextCycle();
    baseAddress = 8'd100;
    start       = 1'b1;
    nextCycle();
    start       = 1'b0;
    runTable(5, 1'b1, "ign");
    repeat (5) nextCycle();
    checkOutput("ign busy stays low", busy, 0);
    checkOutput("ign handshakes", hsCount - hsBase, 5);
    checkOutput("ign done count", doneCount - doneBase, 1);

    // Reset during row 2 READ
    $display("[TB] reset abort");
    fillBasic();
    doneBase = doneCount;
    applyStimulus(8'd0, "abort");
    runTable(2, 1'b0, "abort");
    checkOutput("abort in row2 read", memRdEn, 1);
    rst = 1'b1;
    nextCycle();
    checkOutput("abort busy", busy, 0);
    checkOutput("abort out_valid", outValid, 0);
    checkOutput("abort mem_rd_en", memRdEn, 0);
    checkOutput("abort done", done, 0);
    checkOutput("abort mem_addr", memAddr, 0);
    checkOutput("abort out0", out0, 0);
    rst = 1'b0;
    repeat (4) nextCycle();
    checkOutput("abort no done", doneCount - doneBase, 0);
    checkOutput("abort stays idle", busy, 0);

    fillBasic();
    applyStimulus(8'd0, "fresh");
    runTable(5, 1'b1, "fresh");

    checkOutput("mem_rd_en outside READ", rdEnViol, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/result_mem_reader.md
Name: result_mem_reader

Overview:
Read-back engine for the systolic array's result memory, the reading end of the FIFO_MEM write path. FIFO_MEM fills an N x N result matrix, row-major, starting at a base address, then raises com. This block reads that matrix back through a synchronous-read memory port. It assembles each row into an N-lane buffer and streams rows out with a valid/ready handshake, pulsing done after the last row.

Parameters:
DATA_W, 32, width of one matrix element / memory word
ADDR_W, 8, memory address width (matches base_address)
N, 5, matrix dimension; lanes per row and rows per matrix

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
start  input  1  single-cycle request; sampled only in IDLE
base_address  input  ADDR_W  address of element [0][0], latched on accepted start
mem_rd_en  output  1  memory read strobe
mem_addr  output  ADDR_W  memory read address
mem_rdata  input  DATA_W  read data, valid the cycle after mem_rd_en
out0..out4  output  DATA_W each  row lanes, column 0..N-1 (N=5)
out_row  output  3  index of the row being presented (clog2(N))
out_valid  output  1  row on out0..out4 is valid
out_ready  input  1  consumer accepts the row when out_valid && out_ready
busy  output  1  high from the cycle after an accepted start until done
done  output  1  one-cycle pulse after the last row is accepted

Behaviour:
- Clock is clk. Reset rst is synchronous, active-high.
- Reset values: state=IDLE; busy, done, out_valid, mem_rd_en = 0; mem_addr, out_row, out0..out4 = 0; row and col counters = 0.
- A reset mid-operation aborts immediately. On the next cycle the block is in IDLE with all outputs at reset values, and no done pulse is produced.
- IDLE: start=1 latches base_address, clears row and col, then moves to READ. A start received in any other state is ignored.
- READ: mem_rd_en=1 and mem_addr = base + row*N + col, truncated mod 2^ADDR_W so the address wraps past the top of memory. col increments each cycle. The word returned one cycle later is written into lane col_d, where col_d is col delayed by one cycle. After issuing col=N-1, the FSM moves to FILL.
- FILL: one cycle with mem_rd_en=0. It captures the last word, then moves to PRESENT.
- PRESENT: out_valid=1, out_row=row, and the lanes show the row buffer.
  - Lanes and out_row hold stable while out_ready=0.
  - On handshake with row<N-1: row increments, col=0, FSM goes to READ.
  - On handshake with row=N-1: FSM goes to DONE.
- DONE: done=1 for one cycle, busy drops, FSM returns to IDLE.
- After a handshake, the lanes keep their last values; only out_valid drops.
- Timing with start sampled at edge t0 and out_ready held high:
  - READ occupies cycles t0+1..t0+5, FILL is t0+6.
  - Row r is valid at cycle t0+7+7r.
  - The last row is valid at t0+35; done is high at t0+36.
  - busy is high during t0+1..t0+35.
- mem_rd_en is never asserted outside READ.

Optional Feature:
RESULT_READER_TRANSPOSE_EN. When defined, the element address is base + col*N + row, so each presented row is a column of the stored matrix. Timing, handshake and wrap rules are unchanged. When not defined, the address is row-major as described in Behaviour.

Test Plan:
- Setup for all tests: memory model with 1-cycle read latency, mem[i] = i+1.
- Basic read: base=0, out_ready=1, start pulse at t0 -> row0 = {1,2,3,4,5} valid at t0+7; row4 = {21,22,23,24,25} valid at t0+35; done=1 only at t0+36; busy=0 afterwards.
- Backpressure: out_ready=0 for 3 cycles while row1 is presented -> out0..out4 hold {6..10} with out_row=1; row2 is valid at t0+24 instead of t0+21; exactly 5 handshakes and 1 done.
- Address wrap: base=250 -> row0 = mem[250..254]; row1 = {mem[255], mem[0], mem[1], mem[2], mem[3]}; no mem_addr value ever exceeds 255.
- Reset and ignored start: a second start while busy has no effect and only one done occurs. rst=1 during row2's READ -> next cycle busy=0, out_valid=0, mem_rd_en=0, no done. A fresh start then reads row0 = {1..5}.
- Transpose (with RESULT_READER_TRANSPOSE_EN defined): base=0 -> row0 = {1,6,11,16,21}, row4 = {5,10,15,20,25}, same cycle timing as the basic read.
